// File: rtl/conv2d_engine.sv
// KxK signed 2-D convolution over an image in synchronous RAM; one
// accumulated result per output position on a valid/ready stream.
// Ports: i_clk/i_rst_n, start/stride/bases in, kernel and image RAM
// address out + data in, o_out_data/o_out_valid/i_out_ready, o_busy/o_done.
module conv2d_engine #(
  parameter int DATA_W     = 8,
  parameter int K          = 3,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int ADDR_W     = 16,
  parameter int MAX_STRIDE = 4,
  parameter int ACC_W      = 2*DATA_W + $clog2(K*K)
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_start,
  input  logic [$clog2(MAX_STRIDE+1)-1:0]   i_stride,
  input  logic [ADDR_W-1:0]                 i_src_base,
  input  logic [ADDR_W-1:0]                 i_ker_base,
  output logic [ADDR_W-1:0]                 o_ker_addr,
  input  logic [DATA_W-1:0]                 i_ker_data,
  output logic [ADDR_W-1:0]                 o_src_addr,
  input  logic [DATA_W-1:0]                 i_src_data,
  output logic [ACC_W-1:0]                  o_out_data,
  output logic                              o_out_valid,
  input  logic                              i_out_ready,
  output logic                              o_busy,
  output logic                              o_done
);

  localparam int KK    = K*K;
  localparam int CNT_W = $clog2(KK+1);
  localparam int KI_W  = (KK > 1) ? $clog2(KK) : 1;
  localparam int KX_W  = (K > 1) ? $clog2(K) : 1;
  localparam int SW    = $clog2(MAX_STRIDE+1);
  localparam int POS_W = $clog2(IMG_W+IMG_H+MAX_STRIDE+1);

  typedef enum logic [2:0] {
    IDLE, LOAD_KER, MAC, OUT, DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [KX_W-1:0]           kx_q, kx_d;
  logic [SW-1:0]             stride_q, stride_d;
  logic [ADDR_W-1:0]         row_q, row_d;
  logic [ADDR_W-1:0]         win_q, win_d;
  logic [POS_W-1:0]          cx_q, cx_d;
  logic [POS_W-1:0]          ry_q, ry_d;
  logic [ADDR_W-1:0]         src_addr_q, src_addr_d;
  logic [ADDR_W-1:0]         ker_addr_q, ker_addr_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic signed [DATA_W-1:0]  ker_q [KK];
  logic signed [DATA_W-1:0]  ker_d [KK];

  logic [CNT_W-1:0]          cnt_m1;
  logic [KI_W-1:0]           tap_idx;
  logic signed [2*DATA_W-1:0] prod;
  logic [ADDR_W-1:0]         row_step;
  logic                      last_col;
  logic                      last_row;

  // RAM data lags its address by one cycle, so the tap consumed
  // this cycle is the one issued on the previous count.
  assign cnt_m1   = cnt_q - 1'b1;
  assign tap_idx  = KI_W'(cnt_m1);
  assign prod     = $signed(i_src_data) * ker_q[tap_idx];
  assign row_step = row_q + ADDR_W'(stride_q * IMG_W);

  // A window is last in its row/column when the next stride step
  // would push the kernel past the image edge.
  assign last_col = (cx_q + POS_W'(stride_q)) > POS_W'(IMG_W-K);
  assign last_row = (ry_q + POS_W'(stride_q)) > POS_W'(IMG_H-K);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    kx_d       = kx_q;
    stride_d   = stride_q;
    row_d      = row_q;
    win_d      = win_q;
    cx_d       = cx_q;
    ry_d       = ry_q;
    src_addr_d = src_addr_q;
    ker_addr_d = ker_addr_q;
    acc_d      = acc_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ker_d      = ker_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d    = LOAD_KER;
          busy_d     = 1'b1;
          cnt_d      = '0;
          ker_addr_d = i_ker_base;
          row_d      = i_src_base;
          win_d      = i_src_base;
          cx_d       = '0;
          ry_d       = '0;
          if (i_stride == '0 || i_stride > SW'(MAX_STRIDE))
            stride_d = SW'(1);
          else
            stride_d = i_stride;
        end
      end
      LOAD_KER: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q != '0)
          ker_d[tap_idx] = i_ker_data;
        if (cnt_q < CNT_W'(KK-1))
          ker_addr_d = ker_addr_q + 1'b1;
        if (cnt_q == CNT_W'(KK)) begin
          state_d    = MAC;
          cnt_d      = '0;
          kx_d       = '0;
          src_addr_d = win_q;
          acc_d      = '0;
        end
      end
      MAC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q != '0)
          acc_d = acc_q + ACC_W'(prod);
        if (cnt_q < CNT_W'(KK-1)) begin
          if (kx_q == KX_W'(K-1)) begin
            kx_d       = '0;
            src_addr_d = src_addr_q + ADDR_W'(IMG_W-K+1);
          end else begin
            kx_d       = kx_q + 1'b1;
            src_addr_d = src_addr_q + 1'b1;
          end
        end
        if (cnt_q == CNT_W'(KK)) begin
          state_d = OUT;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      OUT: begin
        if (i_out_ready) begin
          valid_d = 1'b0;
          if (last_col && last_row) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = MAC;
            acc_d   = '0;
            cnt_d   = '0;
            kx_d    = '0;
            if (last_col) begin
              cx_d       = '0;
              ry_d       = ry_q + POS_W'(stride_q);
              row_d      = row_step;
              win_d      = row_step;
              src_addr_d = row_step;
            end else begin
              cx_d       = cx_q + POS_W'(stride_q);
              win_d      = win_q + ADDR_W'(stride_q);
              src_addr_d = win_q + ADDR_W'(stride_q);
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      kx_q       <= '0;
      stride_q   <= SW'(1);
      row_q      <= '0;
      win_q      <= '0;
      cx_q       <= '0;
      ry_q       <= '0;
      src_addr_q <= '0;
      ker_addr_q <= '0;
      acc_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < KK; i++)
        ker_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kx_q       <= kx_d;
      stride_q   <= stride_d;
      row_q      <= row_d;
      win_q      <= win_d;
      cx_q       <= cx_d;
      ry_q       <= ry_d;
      src_addr_q <= src_addr_d;
      ker_addr_q <= ker_addr_d;
      acc_q      <= acc_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ker_q      <= ker_d;
    end
  end

  assign o_ker_addr  = ker_addr_q;
  assign o_src_addr  = src_addr_q;
  assign o_out_data  = acc_q;
  assign o_out_valid = valid_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_conv2d_engine.sv
// Directed bench for conv2d_engine on a 5x5 image with a 3x3 kernel:
// table of runs plus stall, start-at-done and mid-run reset sequences.
module tb_conv2d_engine;

  localparam int DW  = 8;
  localparam int K   = 3;
  localparam int IW  = 5;
  localparam int IH  = 5;
  localparam int AW  = 16;
  localparam int MS  = 4;
  localparam int ACW = 2*DW + $clog2(K*K);
  localparam int SB  = 'h40;
  localparam int KB  = 'h10;
  localparam int NV  = 9;

  logic            clk;
  logic            rst_n;
  logic            i_start;
  logic [2:0]      i_stride;
  logic [AW-1:0]   o_ker_addr;
  logic [DW-1:0]   ker_data;
  logic [AW-1:0]   o_src_addr;
  logic [DW-1:0]   src_data;
  logic [ACW-1:0]  o_out_data;
  logic            o_out_valid;
  logic            i_out_ready;
  logic            o_busy;
  logic            o_done;

  conv2d_engine #(
    .DATA_W(DW), .K(K), .IMG_W(IW), .IMG_H(IH),
    .ADDR_W(AW), .MAX_STRIDE(MS)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(i_start),
    .i_stride(i_stride),
    .i_src_base(AW'(SB)),
    .i_ker_base(AW'(KB)),
    .o_ker_addr(o_ker_addr),
    .i_ker_data(ker_data),
    .o_src_addr(o_src_addr),
    .i_src_data(src_data),
    .o_out_data(o_out_data),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  logic [DW-1:0] ker_mem [256];
  logic [DW-1:0] src_mem [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ker_data <= ker_mem[o_ker_addr[7:0]];
    src_data <= src_mem[o_src_addr[7:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int got[$];
  int done_cnt;
  int first_valid;
  int win1;
  bit cap_next;
  int start_cyc;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cap_next) begin
        win1     = int'(o_src_addr);
        cap_next = 1'b0;
      end
      if (o_out_valid && first_valid < 0)
        first_valid = cyc;
      if (o_out_valid && i_out_ready) begin
        got.push_back(int'($signed(o_out_data)));
        if (got.size() == 1)
          cap_next = 1'b1;
      end
      if (o_done)
        done_cnt++;
    end
  end

  typedef struct packed {
    int stride;
    int kk;
    int ik;
    int restart;
    int n;
    int w1;
  } vec_t;

  vec_t vt [NV];
  int   ex [NV][9];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic load_mem(input int kk, input int ik);
    for (int i = 0; i < 256; i++) begin
      ker_mem[i] = '0;
      src_mem[i] = '0;
    end
    for (int n = 0; n < 9; n++) begin
      case (kk)
        0: ker_mem[KB+n] = (n == 4) ? 8'd1 : 8'd0;
        1: ker_mem[KB+n] = 8'd1;
        2: ker_mem[KB+n] = 8'h80;
        default: ker_mem[KB+n] = 8'(n - 4);
      endcase
    end
    for (int p = 0; p < IW*IH; p++) begin
      case (ik)
        0: src_mem[SB+p] = 8'(p);
        1: src_mem[SB+p] = 8'd1;
        default: src_mem[SB+p] = 8'd127;
      endcase
    end
  endtask

  task automatic start_run(input int s);
    got.delete();
    done_cnt    = 0;
    first_valid = -1;
    win1        = -1;
    cap_next    = 1'b0;
    @(posedge clk); #1;
    i_stride = 3'(s);
    i_start  = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    i_start   = 1'b0;
  endtask

  task automatic finish_run(input int vi);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (40) begin
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d done pulses", vi), done_cnt, 1);
    chk($sformatf("v%0d busy idle", vi), int'(o_busy), 0);
    chk($sformatf("v%0d count", vi), got.size(), vt[vi].n);
    for (int i = 0; i < vt[vi].n; i++)
      chk($sformatf("v%0d out%0d", vi, i),
          (i < got.size()) ? got[i] : 32'h7fffffff, ex[vi][i]);
    chk($sformatf("v%0d latency", vi), first_valid - start_cyc, 20);
    if (vt[vi].n > 1)
      chk($sformatf("v%0d win1 addr", vi), win1, vt[vi].w1);
  endtask

  task automatic run_vec(input int vi);
    load_mem(vt[vi].kk, vt[vi].ik);
    start_run(vt[vi].stride);
    if (vt[vi].restart != 0) begin
      repeat (30) @(posedge clk);
      #1 i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
    end
    finish_run(vi);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, int'(o_out_valid), 0);
    chk({tag, " busy"}, int'(o_busy), 0);
    chk({tag, " done"}, int'(o_done), 0);
    chk({tag, " data"}, int'(o_out_data), 0);
    chk({tag, " ker_addr"}, int'(o_ker_addr), 0);
    chk({tag, " src_addr"}, int'(o_src_addr), 0);
  endtask

  initial begin
    int n;
    vt[0] = '{1, 0, 0, 0, 9, SB+1};
    vt[1] = '{2, 1, 1, 0, 4, SB+2};
    vt[2] = '{1, 2, 2, 0, 9, SB+1};
    vt[3] = '{0, 0, 0, 1, 9, SB+1};
    vt[4] = '{7, 0, 0, 0, 9, SB+1};
    vt[5] = '{3, 0, 0, 0, 1, 0};
    vt[6] = '{4, 0, 0, 0, 1, 0};
    vt[7] = '{2, 0, 0, 0, 4, SB+2};
    vt[8] = '{1, 3, 0, 0, 9, SB+1};
    ex[0] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
    ex[1] = '{9, 9, 9, 9, 0, 0, 0, 0, 0};
    ex[2] = '{-146304, -146304, -146304, -146304, -146304,
              -146304, -146304, -146304, -146304};
    ex[3] = ex[0];
    ex[4] = ex[0];
    ex[5] = '{6, 0, 0, 0, 0, 0, 0, 0, 0};
    ex[6] = ex[5];
    ex[7] = '{6, 8, 16, 18, 0, 0, 0, 0, 0};
    ex[8] = '{96, 96, 96, 96, 96, 96, 96, 96, 96};

    rst_n       = 1'b1;
    i_start     = 1'b0;
    i_stride    = 3'd1;
    i_out_ready = 1'b1;
    done_cnt    = 0;
    first_valid = -1;
    win1        = -1;
    cap_next    = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int vi = 0; vi < NV; vi++)
      run_vec(vi);

    // back-pressure on the third result
    load_mem(0, 0);
    start_run(1);
    n = 0;
    while (got.size() < 2 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    i_out_ready = 1'b0;
    while (!o_out_valid && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp data", int'($signed(o_out_data)), 8);
    chk("bp addr", int'(o_src_addr), SB+14);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp hold valid", int'(o_out_valid), 1);
      chk("bp hold data", int'($signed(o_out_data)), 8);
      chk("bp hold addr", int'(o_src_addr), SB+14);
    end
    i_out_ready = 1'b1;
    finish_run(0);

    // start coinciding with the done pulse
    load_mem(0, 0);
    start_run(1);
    n = 0;
    while (!o_done && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done seen", int'(o_done), 1);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (4) begin
      chk("start at done busy", int'(o_busy), 0);
      @(posedge clk); #1;
    end
    finish_run(0);

    // reset during the fourth result
    load_mem(0, 0);
    start_run(1);
    n = 0;
    while (!(got.size() == 3 && o_out_valid) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid count", got.size(), 3);
    chk("mid valid", int'(o_out_valid), 1);
    rst_n = 1'b0;
    #1 chk_zero("mid reset");
    repeat (3) @(posedge clk);
    #1 chk_zero("mid held");
    chk("mid no done", done_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
